// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types for the coherence controller.
// Word, RAM handshake and controller state encodings.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IFETCH = 3'd1,
    DWB    = 3'd2,
    SNOOP  = 3'd3,
    RAMRD  = 3'd4,
    C2C    = 3'd5
  } cc_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves to the
// core that was not served once a request completes.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_ack,
  input  logic       i_ack_id,
  output logic [1:0] o_gnt
);

  logic r_ptr;
  logic w_oth;

  assign w_oth = ~r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (i_ack) begin
      r_ptr <= ~i_ack_id;
    end
  end

  always_comb begin
    o_gnt = '0;
    if (i_req[r_ptr]) begin
      o_gnt[r_ptr] = 1'b1;
    end else if (i_req[w_oth]) begin
      o_gnt[w_oth] = 1'b1;
    end
  end

endmodule

// File: rtl/coherence_mem_ctrl.sv
// Memory-side MSI snoop controller for a 2-core system:
// arbitrates icache/dcache requests onto one RAM port.
module coherence_mem_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CPUS     = 2,
  parameter int BLKWORDS = 2
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic      [CPUS-1:0] iREN,
  input  word_t     [CPUS-1:0] iaddr,
  output logic      [CPUS-1:0] iwait,
  output word_t     [CPUS-1:0] iload,
  input  logic      [CPUS-1:0] dREN,
  input  logic      [CPUS-1:0] dWEN,
  input  word_t     [CPUS-1:0] daddr,
  input  word_t     [CPUS-1:0] dstore,
  output logic      [CPUS-1:0] dwait,
  output word_t     [CPUS-1:0] dload,
  input  logic      [CPUS-1:0] cctrans,
  input  logic      [CPUS-1:0] ccwrite,
  output logic      [CPUS-1:0] ccwait,
  output logic      [CPUS-1:0] ccinv,
  output word_t     [CPUS-1:0] ccsnoopaddr,
  output logic                 ramREN,
  output logic                 ramWEN,
  output word_t                ramaddr,
  output word_t                ramstore,
  input  word_t                ramload,
  input  ramstate_t            ramstate
);

  localparam int CW = (BLKWORDS > 1) ? $clog2(BLKWORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLKWORDS - 1);

  cc_state_t     r_state;
  cc_state_t     w_next;
  logic          r_g;
  logic          w_g_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_p;
  logic          w_acc;
  logic          w_live;
  logic          w_iack;
  logic          w_dack;
  logic [1:0]    w_igrt;
  logic [1:0]    w_dgrt;

  assign w_p   = ~r_g;
  assign w_acc = (ramstate == ACCESS);

  rr_arb2 u_iarb (
    .clk     (CLK),
    .rst_n   (nRST),
    .i_req   (iREN),
    .i_ack   (w_iack),
    .i_ack_id(r_g),
    .o_gnt   (w_igrt)
  );

  rr_arb2 u_darb (
    .clk     (CLK),
    .rst_n   (nRST),
    .i_req   (dREN | dWEN),
    .i_ack   (w_dack),
    .i_ack_id(r_g),
    .o_gnt   (w_dgrt)
  );

  // Requester still holds the request that owns the current state
  always_comb begin
    w_live = 1'b0;
    unique case (r_state)
      IFETCH:     w_live = iREN[r_g];
      DWB:        w_live = dWEN[r_g];
      SNOOP:      w_live = dREN[r_g] | cctrans[r_g];
      RAMRD, C2C: w_live = dREN[r_g];
      default:    w_live = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_g     <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_g     <= w_g_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_g_nxt   = r_g;
    w_cnt_nxt = r_cnt;
    w_iack    = 1'b0;
    w_dack    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (|w_dgrt) begin
          w_g_nxt = w_dgrt[1];
          if (dWEN[w_dgrt[1]] && !cctrans[w_dgrt[1]]) begin
            w_next = DWB;
          end else begin
            w_next = SNOOP;
          end
        end else if (|w_igrt) begin
          w_g_nxt = w_igrt[1];
          w_next  = IFETCH;
        end
      end
      IFETCH: begin
        if (!w_live) begin
          w_next = IDLE;
        end else if (w_acc) begin
          w_next = IDLE;
          w_iack = 1'b1;
        end
      end
      SNOOP: begin
        if (!w_live) begin
          w_next = IDLE;
        end else if (cctrans[w_p]) begin
          w_next = ccwrite[w_p] ? C2C : RAMRD;
        end
      end
      DWB, RAMRD, C2C: begin
        if (!w_live) begin
          w_next    = IDLE;
          w_cnt_nxt = '0;
        end else if (w_acc) begin
          if (r_cnt == LAST) begin
            w_next    = IDLE;
            w_cnt_nxt = '0;
            w_dack    = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_next    = IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    iwait       = '1;
    iload       = '0;
    dwait       = '1;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    unique case (r_state)
      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr[r_g];
        if (w_acc && w_live) begin
          iwait[r_g] = 1'b0;
          iload[r_g] = ramload;
        end
      end
      DWB: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[r_g];
        ramstore = dstore[r_g];
        if (w_acc && w_live) begin
          dwait[r_g] = 1'b0;
        end
      end
      SNOOP: begin
        ccwait[w_p]      = 1'b1;
        ccsnoopaddr[w_p] = daddr[r_g];
        ccinv[w_p]       = ccwrite[r_g];
      end
      RAMRD: begin
        ramREN  = 1'b1;
        ramaddr = daddr[r_g];
        if (w_acc && w_live) begin
          dwait[r_g] = 1'b0;
          dload[r_g] = ramload;
        end
      end
      C2C: begin
        // Snoopee's write-back feeds RAM and the requester at once
        ccwait[w_p]      = 1'b1;
        ccsnoopaddr[w_p] = daddr[r_g];
        ramWEN           = 1'b1;
        ramaddr          = daddr[w_p];
        ramstore         = dstore[w_p];
        dload[r_g]       = dstore[w_p];
        if (w_acc && w_live) begin
          dwait[r_g] = 1'b0;
          dwait[w_p] = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_coherence_mem_ctrl.sv
// Directed bench for coherence_mem_ctrl: arbitration,
// snoop/C2C, eviction, RAM retry and async reset.
module tb_coherence_mem_ctrl;
  import cpu_types_pkg::*;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [1:0]       iREN;
  logic [1:0][31:0] iaddr;
  logic [1:0]       iwait;
  logic [1:0][31:0] iload;
  logic [1:0]       dREN;
  logic [1:0]       dWEN;
  logic [1:0][31:0] daddr;
  logic [1:0][31:0] dstore;
  logic [1:0]       dwait;
  logic [1:0][31:0] dload;
  logic [1:0]       cctrans;
  logic [1:0]       ccwrite;
  logic [1:0]       ccwait;
  logic [1:0]       ccinv;
  logic [1:0][31:0] ccsnoopaddr;
  logic             ramREN;
  logic             ramWEN;
  logic [31:0]      ramaddr;
  logic [31:0]      ramstore;
  logic [31:0]      ramload;
  ramstate_t        ramstate;

  int vecs = 0;
  int errs = 0;

  coherence_mem_ctrl #(.CPUS(2), .BLKWORDS(2)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .dREN       (dREN),
    .dWEN       (dWEN),
    .daddr      (daddr),
    .dstore     (dstore),
    .dwait      (dwait),
    .dload      (dload),
    .cctrans    (cctrans),
    .ccwrite    (ccwrite),
    .ccwait     (ccwait),
    .ccinv      (ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramREN     (ramREN),
    .ramWEN     (ramWEN),
    .ramaddr    (ramaddr),
    .ramstore   (ramstore),
    .ramload    (ramload),
    .ramstate   (ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    nRST     = 1'b0;
    iREN     = '0;
    iaddr    = '0;
    dREN     = '0;
    dWEN     = '0;
    daddr    = '0;
    dstore   = '0;
    cctrans  = '0;
    ccwrite  = '0;
    ramload  = '0;
    ramstate = FREE;

    // reset state
    cyc(); cyc(); #1;
    chk("rst_iwait", 32'(iwait), 32'h3);
    chk("rst_dwait", 32'(dwait), 32'h3);
    chk("rst_ramren", 32'(ramREN), 32'h0);
    chk("rst_ramwen", 32'(ramWEN), 32'h0);
    chk("rst_ccwait", 32'(ccwait), 32'h0);
    chk("rst_ccinv", 32'(ccinv), 32'h0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_iload0", iload[0], 32'h0);
    nRST = 1'b1;

    // two icaches, round robin
    iREN     = 2'b11;
    iaddr[0] = 32'h100;
    iaddr[1] = 32'h200;
    ramstate = BUSY;
    cyc(); #1;
    chk("if0_ren", 32'(ramREN), 32'h1);
    chk("if0_addr", ramaddr, 32'h100);
    chk("if0_busy_iwait", 32'(iwait), 32'h3);
    cyc();
    ramstate = ACCESS;
    ramload  = 32'hA000_0100;
    #1;
    chk("if0_iwait", 32'(iwait), 32'h2);
    chk("if0_iload", iload[0], 32'hA000_0100);
    chk("if0_iload1", iload[1], 32'h0);
    cyc();
    iREN     = 2'b10;
    ramstate = BUSY;
    #1;
    chk("if_idle_ren", 32'(ramREN), 32'h0);
    cyc(); #1;
    chk("if1_addr", ramaddr, 32'h200);
    cyc();
    ramstate = ACCESS;
    ramload  = 32'hB000_0200;
    #1;
    chk("if1_iwait", 32'(iwait), 32'h1);
    chk("if1_iload", iload[1], 32'hB000_0200);
    cyc();
    iREN     = 2'b11;
    ramstate = BUSY;
    cyc(); #1;
    chk("rr_back_addr", ramaddr, 32'h100);

    // async reset in the middle of a fetch
    nRST = 1'b0;
    #1;
    chk("midrst_iwait", 32'(iwait), 32'h3);
    chk("midrst_ramren", 32'(ramREN), 32'h0);
    chk("midrst_addr", ramaddr, 32'h0);
    iREN     = 2'b00;
    nRST     = 1'b1;
    ramstate = FREE;
    cyc(); #1;
    chk("post_rst_ren", 32'(ramREN), 32'h0);

    // dcache beats icache; snoop to RAM read
    dREN     = 2'b01;
    daddr[0] = 32'h300;
    iREN     = 2'b10;
    iaddr[1] = 32'h200;
    cyc(); #1;
    chk("d_beats_i_ren", 32'(ramREN), 32'h0);
    chk("snp_ccwait", 32'(ccwait), 32'h2);
    chk("snp_addr", ccsnoopaddr[1], 32'h300);
    chk("snp_ccinv", 32'(ccinv), 32'h0);
    cyc();
    cctrans = 2'b10;
    ccwrite = 2'b00;
    #1;
    chk("snp_hold_ccwait", 32'(ccwait), 32'h2);
    cyc();
    cctrans  = 2'b00;
    ramstate = ACCESS;
    ramload  = 32'hC000_0300;
    #1;
    chk("rd0_ren", 32'(ramREN), 32'h1);
    chk("rd0_addr", ramaddr, 32'h300);
    chk("rd0_ccwait", 32'(ccwait), 32'h0);
    chk("rd0_dwait", 32'(dwait), 32'h2);
    chk("rd0_dload", dload[0], 32'hC000_0300);
    cyc();
    daddr[0] = 32'h304;
    ramload  = 32'hC000_0304;
    #1;
    chk("rd1_addr", ramaddr, 32'h304);
    chk("rd1_dwait", 32'(dwait), 32'h2);
    chk("rd1_dload", dload[0], 32'hC000_0304);
    cyc();
    dREN     = 2'b00;
    ramstate = FREE;
    #1;
    chk("rd_done_dwait", 32'(dwait), 32'h3);
    cyc();
    ramstate = ACCESS;
    ramload  = 32'hB000_0200;
    #1;
    chk("i_after_d_addr", ramaddr, 32'h200);
    chk("i_after_d_iwait", 32'(iwait), 32'h1);
    cyc();
    iREN     = 2'b00;
    ramstate = BUSY;

    // BusRdX hits M in core1: cache-to-cache
    dREN     = 2'b01;
    cctrans  = 2'b01;
    ccwrite  = 2'b01;
    daddr[0] = 32'h80;
    cyc(); #1;
    chk("c2c_ccinv", 32'(ccinv), 32'h2);
    chk("c2c_snpaddr", ccsnoopaddr[1], 32'h80);
    cctrans = 2'b11;
    ccwrite = 2'b11;
    cyc();
    dWEN      = 2'b10;
    daddr[1]  = 32'h80;
    dstore[1] = 32'hDEAD_BEEF;
    #1;
    chk("c2c_ramwen", 32'(ramWEN), 32'h1);
    chk("c2c_addr", ramaddr, 32'h80);
    chk("c2c_store", ramstore, 32'hDEAD_BEEF);
    chk("c2c_dload0", dload[0], 32'hDEAD_BEEF);
    chk("c2c_ccwait", 32'(ccwait), 32'h2);
    chk("c2c_busy_dwait", 32'(dwait), 32'h3);
    ramstate = ACCESS;
    #1;
    chk("c2c_w0_dwait", 32'(dwait), 32'h0);
    cyc();
    daddr[1]  = 32'h84;
    dstore[1] = 32'h1234_5678;
    daddr[0]  = 32'h84;
    #1;
    chk("c2c_w1_addr", ramaddr, 32'h84);
    chk("c2c_w1_dload", dload[0], 32'h1234_5678);
    chk("c2c_w1_dwait", 32'(dwait), 32'h0);
    cyc();
    dREN     = 2'b00;
    dWEN     = 2'b00;
    cctrans  = 2'b00;
    ccwrite  = 2'b00;
    ramstate = BUSY;
    #1;
    chk("c2c_done_ccwait", 32'(ccwait), 32'h0);
    chk("c2c_done_ramwen", 32'(ramWEN), 32'h0);

    // core1 evicts a 2-word block
    dWEN      = 2'b10;
    daddr[1]  = 32'h40;
    dstore[1] = 32'h4444_0040;
    cyc(); #1;
    chk("wb0_ramwen", 32'(ramWEN), 32'h1);
    chk("wb0_ramren", 32'(ramREN), 32'h0);
    chk("wb0_addr", ramaddr, 32'h40);
    chk("wb0_store", ramstore, 32'h4444_0040);
    chk("wb0_ccwait", 32'(ccwait), 32'h0);
    ramstate = ACCESS;
    #1;
    chk("wb0_dwait", 32'(dwait), 32'h1);
    cyc();
    daddr[1]  = 32'h44;
    dstore[1] = 32'h4444_0044;
    #1;
    chk("wb1_addr", ramaddr, 32'h44);
    chk("wb1_store", ramstore, 32'h4444_0044);
    chk("wb1_dwait", 32'(dwait), 32'h1);
    chk("wb1_ccwait", 32'(ccwait), 32'h0);
    cyc();
    dWEN     = 2'b00;
    ramstate = ERROR;
    #1;
    chk("wb_done_ramwen", 32'(ramWEN), 32'h0);

    // ERROR retry: strobes held, one ack pulse
    dWEN      = 2'b01;
    daddr[0]  = 32'h60;
    dstore[0] = 32'h6666_0060;
    cyc();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("err_ramwen", 32'(ramWEN), 32'h1);
      chk("err_addr", ramaddr, 32'h60);
      chk("err_store", ramstore, 32'h6666_0060);
      chk("err_dwait", 32'(dwait), 32'h3);
      cyc();
    end
    ramstate = ACCESS;
    #1;
    chk("err_acc_dwait", 32'(dwait), 32'h2);
    chk("err_acc_addr", ramaddr, 32'h60);
    cyc();
    ramstate = FREE;
    dWEN     = 2'b00;
    #1;
    chk("err_one_pulse", 32'(dwait), 32'h3);
    cyc(); #1;
    chk("drop_idle_ramwen", 32'(ramWEN), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
